// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU memory initiator: RV32I width codes,
// FSM state encoding and alignment helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_LOAD  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  function automatic logic is_legal_f3(input logic [2:0] func3);
    return (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
           (func3 == F3_BU) || (func3 == F3_HU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
    case (func3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Natural alignment for the access width; byte accesses are never touched.
  function automatic logic [1:0] align_lo(input logic [2:0] func3, input logic [1:0] addr_lo);
    case (func3)
      F3_H, F3_HU: return {addr_lo[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction: picks the byte/half lane out of a memory word and
// sign- or zero-extends it according to the RV32I width code.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  func3,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[7:0];
    case (lane)
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = lane[1] ? word[31:16] : word[15:0];

    result = '0;
    case (func3)
      F3_B:    result = {{24{byte_v[7]}}, byte_v};
      F3_BU:   result = {24'd0, byte_v};
      F3_H:    result = {{16{half_v[15]}}, half_v};
      F3_HU:   result = {16'd0, half_v};
      F3_W:    result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator on the unified memory data port. Optional misalignment
// trap is enabled by defining LSU_MISALIGN_TRAP_EN (adds io_resp_misalign).
//
// state | meaning
// IDLE  | ready for a request from EX
// STORE | write strobe to memory, one cycle
// LOAD  | address held for READ_LAT cycles, word captured on the last
// RESP  | result presented to WB until taken
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned ADDR_W   = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic              io_req_isStore,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic [31:0]       io_req_wdata,
  input  logic [2:0]        io_req_func3,
  output logic              io_resp_valid,
  input  logic              io_resp_ready,
  output logic [31:0]       io_resp_data,
  output logic [ADDR_W-1:0] io_lsu_mem_dataAddr,
  output logic              io_lsu_mem_writeEn,
  output logic [31:0]       io_lsu_mem_writeData,
  output logic [2:0]        io_lsu_mem_func3,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              io_resp_misalign,
`endif
  input  logic [31:0]       io_mem_lsu_data
);

  localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        func3_q;
  logic [2:0]        cnt_q;
  logic [31:0]       rdata_q;
  logic              mis_q;
  logic              trap_hit;
  logic [31:0]       load_result;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_hit         = is_misaligned(io_req_func3, io_req_addr[1:0]);
  assign io_resp_misalign = (state_q == S_RESP) && mis_q;
`else
  assign trap_hit = 1'b0;
`endif

  lsu_load_align u_align (
    .word   (io_mem_lsu_data),
    .lane   (addr_q[1:0]),
    .func3  (func3_q),
    .result (load_result)
  );

  always_comb begin
    state_d              = state_q;
    io_req_ready         = 1'b0;
    io_resp_valid        = 1'b0;
    io_resp_data         = '0;
    io_lsu_mem_dataAddr  = '0;
    io_lsu_mem_writeEn   = 1'b0;
    io_lsu_mem_writeData = '0;
    io_lsu_mem_func3     = '0;
    case (state_q)
      S_IDLE: begin
        io_req_ready = 1'b1;
        if (io_req_valid) begin
          if (!is_legal_f3(io_req_func3) || trap_hit) state_d = S_RESP;
          else if (io_req_isStore)                    state_d = S_STORE;
          else                                        state_d = S_LOAD;
        end
      end
      S_STORE: begin
        io_lsu_mem_dataAddr  = addr_q;
        io_lsu_mem_func3     = func3_q;
        io_lsu_mem_writeData = wdata_q;
        // Reset kills the strobe in the same cycle so an unissued store is dropped.
        io_lsu_mem_writeEn   = !reset;
        state_d              = S_RESP;
      end
      S_LOAD: begin
        io_lsu_mem_dataAddr = addr_q;
        io_lsu_mem_func3    = func3_q;
        if (cnt_q == 3'd0) state_d = S_RESP;
      end
      S_RESP: begin
        io_resp_valid = 1'b1;
        io_resp_data  = rdata_q;
        if (io_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      func3_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (io_req_valid) begin
            addr_q  <= {io_req_addr[ADDR_W-1:2], align_lo(io_req_func3, io_req_addr[1:0])};
            wdata_q <= io_req_wdata;
            func3_q <= io_req_func3;
            cnt_q   <= LAT_LAST;
            rdata_q <= '0;
            mis_q   <= trap_hit;
          end
        end
        S_LOAD: begin
          if (cnt_q == 3'd0) rdata_q <= load_result;
          else               cnt_q   <= cnt_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: behavioural model with per-cycle
// compare plus directed vectors with literal expectations.
module tb_lsu_mem_initiator;

  localparam int READ_LAT = 3;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        io_req_valid, io_req_ready, io_req_isStore;
  logic [63:0] io_req_addr;
  logic [31:0] io_req_wdata;
  logic [2:0]  io_req_func3;
  logic        io_resp_valid, io_resp_ready;
  logic [31:0] io_resp_data;
  logic [63:0] io_lsu_mem_dataAddr;
  logic        io_lsu_mem_writeEn;
  logic [31:0] io_lsu_mem_writeData;
  logic [2:0]  io_lsu_mem_func3;
  logic [31:0] io_mem_lsu_data;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        io_resp_misalign;
`endif

  always #5 clock = ~clock;

  lsu_mem_initiator #(.READ_LAT(READ_LAT), .ADDR_W(64)) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_isStore(io_req_isStore), .io_req_addr(io_req_addr),
    .io_req_wdata(io_req_wdata), .io_req_func3(io_req_func3),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_data(io_resp_data),
    .io_lsu_mem_dataAddr(io_lsu_mem_dataAddr), .io_lsu_mem_writeEn(io_lsu_mem_writeEn),
    .io_lsu_mem_writeData(io_lsu_mem_writeData), .io_lsu_mem_func3(io_lsu_mem_func3),
`ifdef LSU_MISALIGN_TRAP_EN
    .io_resp_misalign(io_resp_misalign),
`endif
    .io_mem_lsu_data(io_mem_lsu_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: data is only valid once the address has been held READ_LAT cycles.
  logic [31:0] mem [0:1023];
  logic        prev_active = 1'b0;
  logic [63:0] prev_addr = '0;
  int          stable = 0;
  wire         mem_active = !io_lsu_mem_writeEn && (io_lsu_mem_dataAddr != 64'd0);

  always @(posedge clock) begin
    prev_active <= mem_active;
    prev_addr   <= io_lsu_mem_dataAddr;
    if (!mem_active) stable <= 0;
    else if (prev_active && prev_addr == io_lsu_mem_dataAddr) stable <= stable + 1;
    else stable <= 1;
  end

  assign io_mem_lsu_data = (mem_active && stable >= READ_LAT - 1)
                           ? mem[io_lsu_mem_dataAddr[11:2]] : 32'hBAD0BAD0;

  // Behavioural model: what the outputs must be, per phase since acceptance.
  typedef struct packed {
    bit          store_acc;
    bit          access;
    bit          mis;
    int          resp_phase;
    logic [63:0] addr;
    logic [31:0] data;
  } exp_t;

  function automatic exp_t predict(input bit st, input logic [63:0] a, input logic [2:0] f3);
    exp_t        e;
    bit          legal, sgn;
    int          width, sh;
    logic [63:0] ea;
    logic [31:0] w, v, mask;
    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    width = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
    e.mis = TRAP && legal && (a % width != 0);
    e.access = legal && !e.mis;
    ea = a - (a % width);
    e.addr = ea;
    e.store_acc = e.access && st;
    e.resp_phase = !e.access ? 1 : (st ? 2 : READ_LAT + 1);
    e.data = 32'd0;
    if (e.access && !st) begin
      w    = mem[ea[11:2]];
      sh   = 8 * int'(ea % 4);
      mask = (width == 1) ? 32'hFF : (width == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
      sgn  = (f3 == 0) || (f3 == 1);
      v    = (w >> sh) & mask;
      if (sgn && width == 1 && v >= 32'h80)   v = v - 32'h100;
      if (sgn && width == 2 && v >= 32'h8000) v = v - 32'h1_0000;
      e.data = v;
    end
    return e;
  endfunction

  bit          model_on = 1'b0;
  bit          m_busy = 1'b0;
  int          m_phase = 0;
  exp_t        m_e;
  logic [2:0]  m_f3;
  logic [31:0] m_wdata;

  always @(posedge clock) begin
    if (reset) m_busy <= 1'b0;
    else if (!m_busy) begin
      if (io_req_valid) begin
        m_busy  <= 1'b1;
        m_phase <= 1;
        m_e     <= predict(io_req_isStore, io_req_addr, io_req_func3);
        m_f3    <= io_req_func3;
        m_wdata <= io_req_wdata;
      end
    end else if (m_phase >= m_e.resp_phase && io_resp_ready) m_busy <= 1'b0;
    else m_phase <= m_phase + 1;
  end

  bit exp_rv, exp_we, exp_drive;
  always @(negedge clock) begin
    if (model_on) begin
      exp_rv    = m_busy && m_phase >= m_e.resp_phase;
      exp_we    = !reset && m_busy && m_e.store_acc && m_phase == 1;
      exp_drive = m_busy && m_e.access && m_phase < m_e.resp_phase;
      chk("write_en", io_lsu_mem_writeEn, exp_we);
      if (!reset) begin
        chk("req_ready", io_req_ready, !m_busy);
        chk("resp_valid", io_resp_valid, exp_rv);
        chk("resp_data", io_resp_data, exp_rv ? m_e.data : 32'd0);
        chk("data_addr", io_lsu_mem_dataAddr, exp_drive ? m_e.addr : 64'd0);
        chk("mem_func3", io_lsu_mem_func3, exp_drive ? m_f3 : 3'd0);
        chk("write_data", io_lsu_mem_writeData, exp_we ? m_wdata : 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("resp_misalign", io_resp_misalign, exp_rv && m_e.mis);
`endif
      end
    end
  end

  logic [31:0] r_data;
  int          r_lat, r_we_cnt, r_we_lat;
  bit          r_addr_seen, r_ready_seen, r_mis;

  task automatic do_req(input bit st, input logic [63:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input int hold);
    bit done = 1'b0;
    @(negedge clock);
    io_req_valid = 1'b1; io_req_isStore = st; io_req_addr = a;
    io_req_wdata = wd; io_req_func3 = f3;
    @(posedge clock);
    #1 io_req_valid = 1'b0;
    r_data = 32'hFFFF_FFFF; r_lat = -1; r_we_cnt = 0; r_we_lat = -1;
    r_addr_seen = 1'b0; r_ready_seen = 1'b0; r_mis = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (io_lsu_mem_writeEn) begin r_we_cnt++; r_we_lat = k; end
      if (io_lsu_mem_dataAddr != 64'd0) r_addr_seen = 1'b1;
      if (io_req_ready) r_ready_seen = 1'b1;
      if (io_resp_valid) begin
        if (r_lat < 0) r_lat = k;
        if (k - r_lat >= hold) begin
          r_data = io_resp_data;
`ifdef LSU_MISALIGN_TRAP_EN
          r_mis = io_resp_misalign;
`endif
          io_resp_ready = 1'b1;
          @(posedge clock);
          #1 io_resp_ready = 1'b0;
          done = 1'b1;
          break;
        end
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL resp_timeout: no response within 40 cycles for addr 0x%0h", a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem[10'h80] = 32'h80FF7F01;
    reset = 1'b1; io_req_valid = 1'b0; io_req_isStore = 1'b0; io_req_addr = '0;
    io_req_wdata = '0; io_req_func3 = '0; io_resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    model_on = 1'b1;
    @(negedge clock);
    chk("reset_req_ready", io_req_ready, 1'b1);
    chk("reset_resp_valid", io_resp_valid, 1'b0);
    chk("reset_write_en", io_lsu_mem_writeEn, 1'b0);
    chk("reset_data_addr", io_lsu_mem_dataAddr, 64'd0);

    // SW 0x100
    do_req(1'b1, 64'h100, 32'hDEADBEEF, 3'd2, 0);
    chk("sw_we_count", r_we_cnt, 1);
    chk("sw_we_lat", r_we_lat, 1);
    chk("sw_resp_lat", r_lat, 2);
    chk("sw_resp_data", r_data, 32'd0);

    // Lane extraction on 0x80FF7F01
    do_req(1'b0, 64'h203, '0, 3'd0, 0);
    chk("lb_203", r_data, 32'hFFFFFF80);
    chk("lb_lat", r_lat, READ_LAT + 1);
    do_req(1'b0, 64'h203, '0, 3'd4, 0);
    chk("lbu_203", r_data, 32'h00000080);
    do_req(1'b0, 64'h202, '0, 3'd1, 0);
    chk("lh_202", r_data, 32'hFFFF80FF);
    do_req(1'b0, 64'h200, '0, 3'd5, 0);
    chk("lhu_200", r_data, 32'h00007F01);
    do_req(1'b0, 64'h202, '0, 3'd5, 0);
    chk("lhu_202", r_data, 32'h000080FF);

    // LW with WB stalling for 5 cycles
    do_req(1'b0, 64'h200, '0, 3'd2, 5);
    chk("lw_held_data", r_data, 32'h80FF7F01);
    chk("lw_resp_lat", r_lat, 4);
    chk("lw_no_ready_while_busy", r_ready_seen, 1'b0);

    // Misaligned word load
    do_req(1'b0, 64'h202, '0, 3'd2, 0);
    if (TRAP) begin
      chk("mis_lw_we", r_we_cnt, 0);
      chk("mis_lw_no_addr", r_addr_seen, 1'b0);
      chk("mis_lw_flag", r_mis, 1'b1);
      chk("mis_lw_data", r_data, 32'd0);
      chk("mis_lw_lat", r_lat, 1);
    end else begin
      chk("mis_lw_data", r_data, 32'h80FF7F01);
      chk("mis_lw_lat", r_lat, 4);
    end

    // Byte and misaligned half stores
    do_req(1'b1, 64'h105, 32'h000000AB, 3'd0, 0);
    chk("sb_we_count", r_we_cnt, 1);
    do_req(1'b1, 64'h103, 32'h00001234, 3'd1, 0);
    chk("sh_mis_we_count", r_we_cnt, TRAP ? 0 : 1);

    // Reset the cycle after a store is accepted
    @(negedge clock);
    io_req_valid = 1'b1; io_req_isStore = 1'b1; io_req_addr = 64'h104;
    io_req_wdata = 32'h0000_1234; io_req_func3 = 3'd2;
    @(posedge clock);
    #1 io_req_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk("rst_store_we", io_lsu_mem_writeEn, 1'b0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_req_ready", io_req_ready, 1'b1);
    chk("rst_resp_valid", io_resp_valid, 1'b0);
    chk("rst_we_after", io_lsu_mem_writeEn, 1'b0);
    do_req(1'b0, 64'h201, '0, 3'd4, 0);
    chk("post_rst_lbu", r_data, 32'h0000007F);

    // Illegal func3
    do_req(1'b0, 64'h200, '0, 3'd3, 0);
    chk("ill_resp_lat", r_lat, 1);
    chk("ill_resp_data", r_data, 32'd0);
    chk("ill_no_addr", r_addr_seen, 1'b0);
    do_req(1'b1, 64'h100, 32'h5555_5555, 3'd7, 0);
    chk("ill_store_we", r_we_cnt, 0);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
